matrix_dsp_sequencer: RTL and testbench

- Bus initiator that feeds the memory-mapped Matrix DSP core. It is the master on the DSP core's 8-bit register bus.
- Loads six matrix words once per job, then streams vertices through the core: memory reads, DSP register writes, a trigger, result reads, and memory writes.
- Sits between the system memory bus and the DSP core, and offloads per-vertex register traffic from the CPU.

---
 rtl/matrix_dsp_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_matrix_dsp_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_dsp_sequencer.sv
// matrix_dsp_sequencer
//
// Bus initiator for the memory-mapped Matrix DSP core. For each job it loads
// the six matrix words (A0,A1,B0,B1,C0,C1) into DSP word indices 3..8. It then
// streams every vertex through the core. For each vertex it:
//   - reads x,y,z from memory and writes them to DSP word indices 0..2;
//   - triggers the core by writing 0 to word index 9;
//   - reads the results from word indices 10..12;
//   - writes the results back to memory.
//
// Ports
//   clk, reset          clock (posedge) and asynchronous active-high reset
//   start               one-cycle job request, only honoured while idle
//   matAddr/srcAddr/dstAddr/count
//                       job descriptor, latched when start is accepted
//   busy, done          job in progress / one-cycle end-of-job pulse
//   mem*                memory-side master (address, read, write, data, stall)
//   dsp*                DSP register-bus master (byte address = word index << 2)
//
// Every bus state drives exactly one strobe. Each bus state advances only on
// the cycle its transfer completes (strobe high, waitrequest low). Address,
// data and strobe are decoded from registered state, so they hold still while
// the slave stalls.
module matrix_dsp_sequencer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  matAddr,
    input  logic [ADDR_WIDTH-1:0]  srcAddr,
    input  logic [ADDR_WIDTH-1:0]  dstAddr,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  memAddress,
    output logic                   memRead,
    output logic                   memWrite,
    output logic [31:0]            memWriteData,
    input  logic [31:0]            memReadData,
    input  logic                   memWaitrequest,
    output logic [7:0]             dspAddress,
    output logic                   dspRead,
    output logic                   dspWrite,
    output logic [31:0]            dspWriteData,
    input  logic [31:0]            dspReadData,
    input  logic                   dspWaitrequest
);

    typedef enum logic [3:0] {
        IDLE,
        MAT_RD,
        MAT_WR,
        VTX_RD,
        VTX_WR,
        OP,
        RES_RD,
        RES_WR,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    // DSP register word indices
    localparam logic [5:0] MAT_BASE_WORD = 6'd3;
    localparam logic [5:0] OP_WORD       = 6'd9;
    localparam logic [5:0] RES_BASE_WORD = 6'd10;

    state_t                 state_reg, state_next;
    logic [2:0]             idx_reg, idx_next;
    logic [ADDR_WIDTH-1:0]  mat_ptr_reg, mat_ptr_next;
    logic [ADDR_WIDTH-1:0]  src_ptr_reg, src_ptr_next;
    logic [ADDR_WIDTH-1:0]  dst_ptr_reg, dst_ptr_next;
    logic [COUNT_WIDTH-1:0] remaining_reg, remaining_next;
    logic [31:0]            data_reg, data_next;

    function automatic logic [7:0] word_addr(input logic [5:0] word);
        return {word, 2'b00};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            mat_ptr_reg   <= '0;
            src_ptr_reg   <= '0;
            dst_ptr_reg   <= '0;
            remaining_reg <= '0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            mat_ptr_reg   <= mat_ptr_next;
            src_ptr_reg   <= src_ptr_next;
            dst_ptr_reg   <= dst_ptr_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        mat_ptr_next   = mat_ptr_reg;
        src_ptr_next   = src_ptr_reg;
        dst_ptr_next   = dst_ptr_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;

        memAddress     = '0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        memWriteData   = '0;
        dspAddress     = '0;
        dspRead        = 1'b0;
        dspWrite       = 1'b0;
        dspWriteData   = '0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mat_ptr_next   = matAddr;
                    src_ptr_next   = srcAddr;
                    dst_ptr_next   = dstAddr;
                    remaining_next = count;
                    idx_next       = '0;
                    state_next     = MAT_RD;
                end
            end

            MAT_RD: begin
                memRead    = 1'b1;
                memAddress = mat_ptr_reg;
                if (!memWaitrequest) begin
                    data_next  = memReadData;
                    state_next = MAT_WR;
                end
            end

            MAT_WR: begin
                dspWrite     = 1'b1;
                dspAddress   = word_addr(MAT_BASE_WORD + {3'b000, idx_reg});
                dspWriteData = data_reg;
                if (!dspWaitrequest) begin
                    mat_ptr_next = mat_ptr_reg + WORD_STEP;
                    if (idx_reg == 3'd5) begin
                        idx_next   = '0;
                        // A zero-length job still loads the matrix, then ends.
                        state_next = (remaining_reg != '0) ? VTX_RD : DONE;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = MAT_RD;
                    end
                end
            end

            VTX_RD: begin
                memRead    = 1'b1;
                memAddress = src_ptr_reg;
                if (!memWaitrequest) begin
                    data_next    = memReadData;
                    src_ptr_next = src_ptr_reg + WORD_STEP;
                    state_next   = VTX_WR;
                end
            end

            VTX_WR: begin
                dspWrite     = 1'b1;
                dspAddress   = word_addr({3'b000, idx_reg});
                dspWriteData = data_reg;
                if (!dspWaitrequest) begin
                    if (idx_reg == 3'd2) begin
                        idx_next   = '0;
                        state_next = OP;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = VTX_RD;
                    end
                end
            end

            OP: begin
                // The core keeps waitrequest high for its whole compute time,
                // so completion of this write means results are ready.
                dspWrite     = 1'b1;
                dspAddress   = word_addr(OP_WORD);
                dspWriteData = '0;
                if (!dspWaitrequest) begin
                    idx_next   = '0;
                    state_next = RES_RD;
                end
            end

            RES_RD: begin
                dspRead    = 1'b1;
                dspAddress = word_addr(RES_BASE_WORD + {3'b000, idx_reg});
                if (!dspWaitrequest) begin
                    data_next  = dspReadData;
                    state_next = RES_WR;
                end
            end

            RES_WR: begin
                memWrite     = 1'b1;
                memAddress   = dst_ptr_reg;
                memWriteData = data_reg;
                if (!memWaitrequest) begin
                    dst_ptr_next = dst_ptr_reg + WORD_STEP;
                    if (idx_reg == 3'd2) begin
                        idx_next       = '0;
                        remaining_next = remaining_reg - COUNT_WIDTH'(1);
                        state_next     = (remaining_reg == COUNT_WIDTH'(1)) ? DONE : VTX_RD;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = RES_RD;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy stays high through the DONE cycle and drops as IDLE is re-entered.
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_matrix_dsp_sequencer.sv
module tb_matrix_dsp_sequencer;

    localparam int K_MR = 0;  // memory read
    localparam int K_DW = 1;  // DSP write
    localparam int K_DR = 2;  // DSP read
    localparam int K_MW = 3;  // memory write

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] matAddr, srcAddr, dstAddr;
    logic [15:0] count;
    logic        busy, done;
    logic [31:0] memAddress;
    logic        memRead, memWrite;
    logic [31:0] memWriteData, memReadData;
    logic        memWaitrequest;
    logic [7:0]  dspAddress;
    logic        dspRead, dspWrite;
    logic [31:0] dspWriteData, dspReadData;
    logic        dspWaitrequest;

    always #5 clk = ~clk;

    matrix_dsp_sequencer #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .matAddr        (matAddr),
        .srcAddr        (srcAddr),
        .dstAddr        (dstAddr),
        .count          (count),
        .busy           (busy),
        .done           (done),
        .memAddress     (memAddress),
        .memRead        (memRead),
        .memWrite       (memWrite),
        .memWriteData   (memWriteData),
        .memReadData    (memReadData),
        .memWaitrequest (memWaitrequest),
        .dspAddress     (dspAddress),
        .dspRead        (dspRead),
        .dspWrite       (dspWrite),
        .dspWriteData   (dspWriteData),
        .dspReadData    (dspReadData),
        .dspWaitrequest (dspWaitrequest)
    );

    // Slave models: 4 KB word memory and a 16-word DSP register file.
    logic [31:0] mem_arr  [1024];
    logic [31:0] dsp_regs [16];
    assign memReadData = mem_arr[memAddress[11:2]];
    assign dspReadData = dsp_regs[dspAddress[5:2]];

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    txn_t exp_q[$];
    logic [31:0] exp_res[$];

    bit          mem_stall_en  = 1'b0;
    bit          hold_mem_wait = 1'b0;
    logic [31:0] hold_addr     = '0;
    int          op_delay      = 0;
    int          op_cnt        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic check_xfer(input int k, input logic [31:0] a, input logic [31:0] d);
        txn_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_xfer got kind=%0d addr=%h data=%h required=none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.addr != a || ((k == K_DW || k == K_MW) && e.data != d)) begin
                failures++;
                $display("FAIL xfer got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Slave waitrequest drivers, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        if (memWrite && hold_mem_wait && memAddress == hold_addr)
            memWaitrequest = 1'b1;
        else
            memWaitrequest = mem_stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (dspWrite && dspAddress == 8'h24) begin
            if (op_cnt < op_delay) begin
                dspWaitrequest = 1'b1;
                op_cnt++;
            end else begin
                dspWaitrequest = 1'b0;
            end
        end else begin
            op_cnt         = 0;
            dspWaitrequest = 1'b0;
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each
    // completing transfer and applies the slave-side effects.
    logic [107:0] snap;
    bit           stalled_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev)
                chk("stall_stable",
                    64'({memAddress, memRead, memWrite, memWriteData, dspAddress, dspRead, dspWrite, dspWriteData} != snap),
                    64'd0);
            if ((memRead && memWrite) || (dspRead && dspWrite) ||
                ((memRead || memWrite) && (dspRead || dspWrite)))
                chk("strobe_exclusive", {60'd0, memRead, memWrite, dspRead, dspWrite}, 64'd0);
            if ((memRead || memWrite) && !memWaitrequest) begin
                check_xfer(memWrite ? K_MW : K_MR, memAddress, memWriteData);
                if (memWrite) mem_arr[memAddress[11:2]] = memWriteData;
            end else if (memRead || memWrite) begin
                stall_cnt++;
            end
            if ((dspRead || dspWrite) && !dspWaitrequest) begin
                check_xfer(dspWrite ? K_DW : K_DR, {24'd0, dspAddress}, dspWriteData);
                if (dspWrite) begin
                    dsp_regs[dspAddress[5:2]] = dspWriteData;
                    if (dspAddress == 8'h24)
                        for (int i = 0; i < 3; i++)
                            dsp_regs[10+i] = dsp_regs[i] * dsp_regs[3+2*i] + dsp_regs[4+2*i];
                end
            end else if (dspRead || dspWrite) begin
                stall_cnt++;
            end
            snap = {memAddress, memRead, memWrite, memWriteData, dspAddress, dspRead, dspWrite, dspWriteData};
            stalled_prev = ((memRead || memWrite) && memWaitrequest) || ((dspRead || dspWrite) && dspWaitrequest);
        end
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_arr[a[11:2]];
    endfunction

    function automatic txn_t mk(input int k, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.kind = k;
        t.addr = a;
        t.data = d;
        return t;
    endfunction

    // Reference: the job's bus transfers in order and the vertex results
    // (r = v * M[2i] + M[2i+1] per coordinate, 32-bit wrapping).
    task automatic build(input logic [31:0] mat, src, dst, input int n);
        logic [31:0] m [6];
        logic [31:0] x [3];
        logic [31:0] r;
        exp_res.delete();
        for (int k = 0; k < 6; k++) begin
            m[k] = rd(mat + 32'(4 * k));
            exp_q.push_back(mk(K_MR, mat + 32'(4 * k), '0));
            exp_q.push_back(mk(K_DW, 32'(4 * (3 + k)), m[k]));
        end
        for (int v = 0; v < n; v++) begin
            for (int i = 0; i < 3; i++) begin
                x[i] = rd(src + 32'(12 * v + 4 * i));
                exp_q.push_back(mk(K_MR, src + 32'(12 * v + 4 * i), '0));
                exp_q.push_back(mk(K_DW, 32'(4 * i), x[i]));
            end
            exp_q.push_back(mk(K_DW, 32'h24, 32'd0));
            for (int i = 0; i < 3; i++) begin
                r = x[i] * m[2*i] + m[2*i+1];
                exp_q.push_back(mk(K_DR, 32'(4 * (10 + i)), '0));
                exp_q.push_back(mk(K_MW, dst + 32'(12 * v + 4 * i), r));
                exp_res.push_back(r);
            end
        end
    endtask

    task automatic pulse_start(input logic [31:0] mat, src, dst, input int n, output int t0);
        @(posedge clk);
        #1;
        matAddr = mat;
        srcAddr = src;
        dstAddr = dst;
        count   = 16'(n);
        start   = 1'b1;
        t0      = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_job(input string nm, input logic [31:0] mat, src, dst,
                           input int n, input bit stall, input int opd);
        int t0, s0, got, expd;
        bit ok;
        mem_stall_en = stall;
        op_delay     = opd;
        build(mat, src, dst, n);
        s0 = stall_cnt;
        pulse_start(mat, src, dst, n, t0);
        chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
        got = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 18) start = 1'b0;
            if (done) begin
                got = cyc;
                break;
            end
            if (i == 17) start = 1'b1;  // ignored while busy
        end
        if (got < 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no_done required=done", nm);
        end else begin
            expd = t0 + 13 + 13 * n + (stall ? (stall_cnt - s0) : opd * n);
            chk({nm, "_done_cycle"}, 64'(got - t0), 64'(expd - t0));
        end
        // A start presented in the DONE cycle must be ignored.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        repeat (3) @(negedge clk);
        chk({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        ok = 1'b1;
        for (int i = 0; i < exp_res.size(); i++)
            if (rd(dst + 32'(4 * i)) != exp_res[i]) ok = 1'b0;
        chk({nm, "_dst_contents"}, {63'd0, ok}, 64'd1);
        mem_stall_en = 1'b0;
        op_delay     = 0;
        $display("job %s n=%0d mat=%h src=%h dst=%h done_after=%0d", nm, n, mat, src, dst, got - t0);
    endtask

    task automatic clear_dst(input logic [31:0] dst, input int words);
        for (int i = 0; i < words; i++) mem_arr[(dst[11:2] + 10'(i))] = '0;
    endtask

    initial begin : main
        int t0;
        int found;
        logic [31:0] mat, src, dst;
        int n;

        for (int i = 0; i < 1024; i++) mem_arr[i] = $urandom;
        for (int i = 0; i < 16; i++) dsp_regs[i] = '0;
        reset          = 1'b1;
        start          = 1'b0;
        matAddr        = '0;
        srcAddr        = '0;
        dstAddr        = '0;
        count          = '0;
        memWaitrequest = 1'b0;
        dspWaitrequest = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({busy, done, memRead, memWrite, dspRead, dspWrite} != 6'd0 ||
                memAddress != 0 || memWriteData != 0 || dspAddress != 0 || dspWriteData != 0),
            64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || done || memRead || memWrite || dspRead || dspWrite) found++;
        end
        chk("idle_quiet", 64'(found), 64'd0);

        // Zero-length job: matrix load only.
        run_job("count0", 32'h100, 32'h200, 32'h300, 0, 1'b0, 0);

        // Two vertices, matrix words 1..6.
        for (int k = 0; k < 6; k++) mem_arr[64 + k] = 32'(k + 1);
        clear_dst(32'h300, 6);
        run_job("count2", 32'h100, 32'h200, 32'h300, 2, 1'b0, 0);

        // DSP holds off the trigger write for 5 cycles.
        clear_dst(32'h300, 3);
        run_job("op_wait", 32'h100, 32'h200, 32'h300, 1, 1'b0, 5);

        // Same two-vertex job with random memory stalls.
        clear_dst(32'h300, 6);
        run_job("mem_stall", 32'h100, 32'h200, 32'h300, 2, 1'b1, 0);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            mat = 32'h040 + 32'(4 * $urandom_range(0, 15));
            src = 32'h200 + 32'(4 * $urandom_range(0, 31));
            dst = 32'h600 + 32'(4 * $urandom_range(0, 31));
            n   = int'($urandom_range(0, 4));
            for (int i = 0; i < 6; i++) mem_arr[mat[11:2] + 10'(i)] = $urandom;
            run_job($sformatf("rand%0d", j), mat, src, dst, n,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset while vertex 1's first result write is stalled.
        hold_mem_wait = 1'b1;
        hold_addr     = 32'h300 + 32'd12;
        build(32'h100, 32'h200, 32'h300, 3);
        pulse_start(32'h100, 32'h200, 32'h300, 3, t0);
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (memWrite && memAddress == hold_addr) begin
                found = 1;
                break;
            end
        end
        chk("reset_point_reached", 64'(found), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            64'({busy, done, memRead, memWrite, dspRead, dspWrite} != 6'd0 ||
                memAddress != 0 || memWriteData != 0 || dspAddress != 0),
            64'd0);
        exp_q.delete();
        hold_mem_wait = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || memRead || memWrite || dspRead || dspWrite) found++;
        end
        chk("post_reset_idle", 64'(found), 64'd0);
        clear_dst(32'h300, 9);
        run_job("after_reset", 32'h100, 32'h200, 32'h300, 3, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
